// File: rtl/noc_pkg.sv
// Shared NoC link definitions used by the VC transmitter and the VC receiver.
package noc_pkg;

    localparam int NOC_DATA_W    = 16;
    localparam int NOC_NUM_VC    = 4;
    localparam int NOC_BUF_DEPTH = 4;

    // Width of a VC id field; a single-VC link still carries a 1-bit id.
    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    localparam int NOC_VC_W = vc_width(NOC_NUM_VC);

    // Link-side flit at the default geometry: VC id above payload.
    typedef struct packed {
        logic [NOC_VC_W-1:0]   vc;
        logic [NOC_DATA_W-1:0] data;
    } flit_t;

endpackage

// File: rtl/noc_vc_credit_tx_if.sv
// Local-source, link and credit signals of a VC-aware link transmitter.
interface noc_vc_credit_tx_if
    import noc_pkg::*;
#(
    parameter int DATA_W    = NOC_DATA_W,
    parameter int NUM_VC    = NOC_NUM_VC,
    parameter int BUF_DEPTH = NOC_BUF_DEPTH
);
    localparam int VC_W  = vc_width(NUM_VC);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [NUM_VC-1:0]        in_valid;
    logic [NUM_VC*DATA_W-1:0] in_data;
    logic [NUM_VC-1:0]        in_ready;
    logic                     link_enable;
    logic [VC_W-1:0]          link_vc;
    logic [DATA_W-1:0]        link_data;
    logic                     link_credit;
    logic [VC_W-1:0]          link_credit_vc;
    logic [NUM_VC*CNT_W-1:0]  credit_cnt;
    logic                     credit_err;

    // Environment side: local sources plus the downstream credit return.
    modport master (
        output in_valid, in_data, link_credit, link_credit_vc,
        input  in_ready, link_enable, link_vc, link_data, credit_cnt, credit_err
    );

    // Transmitter side.
    modport slave (
        input  in_valid, in_data, link_credit, link_credit_vc,
        output in_ready, link_enable, link_vc, link_data, credit_cnt, credit_err
    );

endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter  int N     = NOC_NUM_VC,
    localparam int IDX_W = vc_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    // Search indices ptr..N-1 first, then the wrapped-around indices 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && (i >= int'(ptr))) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
                any_gnt = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && (i < int'(ptr))) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_vc_credit_tx.sv
// Credit-based multi-VC link transmitter: round-robin over VCs with credits.
module noc_vc_credit_tx
    import noc_pkg::*;
#(
    parameter int DATA_W    = NOC_DATA_W,
    parameter int NUM_VC    = NOC_NUM_VC,
    parameter int BUF_DEPTH = NOC_BUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    noc_vc_credit_tx_if.slave  bus
);
    localparam int                VC_W    = vc_width(NUM_VC);
    localparam int                CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(BUF_DEPTH);
    localparam logic [VC_W-1:0]   LAST_VC = VC_W'(NUM_VC - 1);

    logic [CNT_W-1:0]         cnt [NUM_VC];
    logic [VC_W-1:0]          rr_ptr;
    logic [NUM_VC-1:0]        eligible;
    logic [NUM_VC-1:0]        gnt;
    logic [VC_W-1:0]          gnt_idx;
    logic                     any_gnt;
    logic [DATA_W-1:0]        gnt_data;
    logic [NUM_VC-1:0]        ret_hit;
    logic [NUM_VC-1:0]        ovf;
    logic                     bad_vc;
    logic [NUM_VC*CNT_W-1:0]  cnt_flat;
    logic                     link_enable_q;
    logic [VC_W-1:0]          link_vc_q;
    logic [DATA_W-1:0]        link_data_q;
    logic                     credit_err_q;

    // A VC may compete only with a flit offered and a registered credit in hand.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        eligible = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            eligible[v] = bus.in_valid[v] && (cnt[v] != '0);
        end
    end

    noc_rr_arbiter #(.N(NUM_VC)) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Select the granted payload and decode the returned credit per VC.
    always_comb begin
        gnt_data = '0;
        ret_hit  = '0;
        ovf      = '0;
        cnt_flat = '0;
        bad_vc   = bus.link_credit && ({1'b0, bus.link_credit_vc} >= (VC_W + 1)'(NUM_VC));
        for (int v = 0; v < NUM_VC; v++) begin
            if (gnt[v]) begin
                gnt_data = bus.in_data[v*DATA_W +: DATA_W];
            end
            ret_hit[v] = bus.link_credit && ({1'b0, bus.link_credit_vc} == (VC_W + 1)'(v));
            ovf[v]     = ret_hit[v] && !gnt[v] && (cnt[v] == FULL);
            cnt_flat[v*CNT_W +: CNT_W] = cnt[v];
        end
    end

    // Link output register and round-robin pointer; idle cycles drive zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_enable_q <= 1'b0;
            link_vc_q     <= '0;
            link_data_q   <= '0;
            rr_ptr        <= '0;
        end else if (any_gnt) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            link_enable_q <= 1'b1;
            link_vc_q     <= gnt_idx;
            link_data_q   <= gnt_data;
            rr_ptr        <= (gnt_idx == LAST_VC) ? '0 : gnt_idx + VC_W'(1);
        end else begin
            link_enable_q <= 1'b0;
            link_vc_q     <= '0;
            link_data_q   <= '0;
        end
    end

    // Per-VC credit counters: send decrements, return increments, both cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is reset because it is the link's initial credit state, not storage.
            for (int v = 0; v < NUM_VC; v++) begin
                cnt[v] <= FULL;
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                case ({gnt[v], ret_hit[v]})
                    2'b10:   cnt[v] <= cnt[v] - CNT_W'(1);
                    2'b01:   if (cnt[v] != FULL) cnt[v] <= cnt[v] + CNT_W'(1);
                    default: cnt[v] <= cnt[v];
                endcase
            end
            if (bad_vc || (|ovf)) begin
                credit_err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = gnt;
    assign bus.link_enable = link_enable_q;
    assign bus.link_vc     = link_vc_q;
    assign bus.link_data   = link_data_q;
    assign bus.credit_cnt  = cnt_flat;
    assign bus.credit_err  = credit_err_q;

endmodule

// File: tb/tb_noc_vc_credit_tx.sv
// Self-checking bench for noc_vc_credit_tx: scoreboarded link flits plus per-scenario checks.
`timescale 1ns/1ps
module tb_noc_vc_credit_tx;
    import noc_pkg::*;

    localparam int DATA_W    = 16;
    localparam int NUM_VC    = 4;
    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_vc_credit_tx_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .BUF_DEPTH(BUF_DEPTH)) bus ();
    noc_vc_credit_tx #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // A 3-VC instance, where id 3 fits the 2-bit field but names no VC.
    noc_vc_credit_tx_if #(.DATA_W(8), .NUM_VC(3), .BUF_DEPTH(2)) bus3 ();
    noc_vc_credit_tx #(.DATA_W(8), .NUM_VC(3), .BUF_DEPTH(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, advanced once per cycle at the falling edge.
    logic [CNT_W-1:0]        m_cnt [NUM_VC];
    logic [NUM_VC*CNT_W-1:0] m_cnt_flat;
    logic [NUM_VC-1:0]       m_ready;
    int                      m_ptr, m_g, m_v;
    bit                      m_err, m_prev, m_snd, m_rtn;
    flit_t                   sb_q [$];
    flit_t                   exp_f;
    flit_t                   new_f;

    always @(negedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) m_cnt[v] = CNT_W'(BUF_DEPTH);
            m_ptr = 0; m_err = 0; m_prev = 0;
            sb_q.delete();
        end else begin
            n_checks++;
            if (bus.link_enable !== m_prev) begin
                n_fail++;
                $display("FAIL sb_link_enable: got %b expected %b at %0t", bus.link_enable, m_prev, $time);
            end
            if (m_prev && sb_q.size() > 0) begin
                exp_f = sb_q.pop_front();
                n_checks++;
                if ({bus.link_vc, bus.link_data} !== exp_f) begin
                    n_fail++;
                    $display("FAIL sb_flit: got %h expected %h at %0t", {bus.link_vc, bus.link_data}, exp_f, $time);
                end
            end else if (!m_prev) begin
                n_checks++;
                if ({bus.link_vc, bus.link_data} !== '0) begin
                    n_fail++;
                    $display("FAIL sb_idle_link: got %h expected 0 at %0t", {bus.link_vc, bus.link_data}, $time);
                end
            end
            for (int v = 0; v < NUM_VC; v++) m_cnt_flat[v*CNT_W +: CNT_W] = m_cnt[v];
            n_checks++;
            if (bus.credit_cnt !== m_cnt_flat) begin
                n_fail++;
                $display("FAIL sb_credit_cnt: got %h expected %h at %0t", bus.credit_cnt, m_cnt_flat, $time);
            end
            n_checks++;
            if (bus.credit_err !== m_err) begin
                n_fail++;
                $display("FAIL sb_credit_err: got %b expected %b at %0t", bus.credit_err, m_err, $time);
            end
            m_g = -1;
            for (int i = 0; i < NUM_VC; i++) begin
                m_v = (m_ptr + i) % NUM_VC;
                if (m_g < 0 && bus.in_valid[m_v] && m_cnt[m_v] != 0) m_g = m_v;
            end
            m_ready = (m_g >= 0) ? (NUM_VC'(1) << m_g) : '0;
            n_checks++;
            if (bus.in_ready !== m_ready) begin
                n_fail++;
                $display("FAIL sb_in_ready: got %b expected %b at %0t", bus.in_ready, m_ready, $time);
            end
            if (m_g >= 0) begin
                new_f.vc   = 2'(m_g);
                new_f.data = bus.in_data[m_g*DATA_W +: DATA_W];
                sb_q.push_back(new_f);
                m_ptr = (m_g + 1) % NUM_VC;
            end
            m_prev = (m_g >= 0);
            for (int v = 0; v < NUM_VC; v++) begin
                m_snd = (m_g == v);
                m_rtn = bus.link_credit && (int'(bus.link_credit_vc) == v);
                if (m_snd && !m_rtn) m_cnt[v] = m_cnt[v] - 1'b1;
                else if (m_rtn && !m_snd) begin
                    if (m_cnt[v] == CNT_W'(BUF_DEPTH)) m_err = 1;
                    else m_cnt[v] = m_cnt[v] + 1'b1;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        bus.in_valid = '0;
        bus.link_credit = 1'b0;
        bus.link_credit_vc = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (bus.link_enable !== 1'b0) begin n_fail++; $display("FAIL reset_link_enable: got %b expected 0", bus.link_enable); end
        n_checks++;
        if (bus.credit_cnt !== {NUM_VC{3'd4}}) begin n_fail++; $display("FAIL reset_credit_cnt: got %h expected %h", bus.credit_cnt, {NUM_VC{3'd4}}); end
        n_checks++;
        if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %b expected 0", bus.credit_err); end
        step();
        bus.in_valid[0] = 1'b1;
        bus.in_data[0 +: DATA_W] = 16'h0abc;
        step();
        bus.in_valid[0] = 1'b0;
        n_checks++;
        if (bus.link_enable !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_enable: got %b expected 1", bus.link_enable); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.link_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_link_enable: got %b expected 0", bus.link_enable); end
        n_checks++;
        if (bus.credit_cnt !== {NUM_VC{3'd4}}) begin n_fail++; $display("FAIL midrst_credit_cnt: got %h expected %h", bus.credit_cnt, {NUM_VC{3'd4}}); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_exhaust;
        int  k, seen, first_c, last_c;
        bit  acc;
        apply_reset();
        k = 0; seen = 0; first_c = -1; last_c = -1;
        bus.in_valid[1] = 1'b1;
        bus.in_data[DATA_W +: DATA_W] = 16'h1000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.link_enable) begin
                n_checks++;
                if (bus.link_vc !== 2'd1 || bus.link_data !== 16'h1000 + 16'(seen)) begin
                    n_fail++;
                    $display("FAIL exhaust_flit: got vc %0d data %h expected vc 1 data %h", bus.link_vc, bus.link_data, 16'h1000 + 16'(seen));
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                seen++;
            end
            acc = bus.in_ready[1];
            step();
            if (acc) begin
                k++;
                bus.in_data[DATA_W +: DATA_W] = 16'h1000 + 16'(k);
            end
        end
        n_checks++;
        if (seen != 4) begin n_fail++; $display("FAIL exhaust_count: got %0d flits expected 4", seen); end
        n_checks++;
        if (last_c - first_c != 3) begin n_fail++; $display("FAIL exhaust_consecutive: got span %0d expected 3", last_c - first_c); end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL exhaust_ready: got %b expected 0", bus.in_ready[1]); end
        n_checks++;
        if (bus.credit_cnt[CNT_W +: CNT_W] !== 3'd0) begin n_fail++; $display("FAIL exhaust_cnt: got %0d expected 0", bus.credit_cnt[CNT_W +: CNT_W]); end
        step();
        bus.link_credit = 1'b1;
        bus.link_credit_vc = 2'd1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL credit_same_cycle_ready: got %b expected 0", bus.in_ready[1]); end
        step();
        bus.link_credit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL credit_next_cycle_ready: got %b expected 1", bus.in_ready[1]); end
        step();
        bus.in_valid[1] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.link_enable !== 1'b1 || bus.link_data !== 16'h1004) begin
            n_fail++;
            $display("FAIL exhaust_refill: got en %b data %h expected en 1 data 1004", bus.link_enable, bus.link_data);
        end
        step();
    endtask

    task automatic test_round_robin;
        apply_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            bus.in_valid[v] = 1'b1;
            bus.in_data[v*DATA_W +: DATA_W] = 16'ha000 + 16'(v * 256);
        end
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                bus.link_credit = 1'b1;
                bus.link_credit_vc = 2'((c - 1) % NUM_VC);
            end
            @(negedge clk);
            if (c > 0) begin
                n_checks++;
                if (bus.link_enable !== 1'b1 || bus.link_vc !== 2'((c - 1) % NUM_VC)) begin
                    n_fail++;
                    $display("FAIL rr_order: cycle %0d got en %b vc %0d expected vc %0d", c, bus.link_enable, bus.link_vc, (c - 1) % NUM_VC);
                end
            end
            step();
        end
        bus.in_valid = '0;
        bus.link_credit = 1'b0;
        step();
    endtask

    task automatic test_send_return;
        apply_reset();
        bus.in_valid[2] = 1'b1;
        bus.in_data[2*DATA_W +: DATA_W] = 16'h2000;
        step();
        bus.in_data[2*DATA_W +: DATA_W] = 16'h2001;
        step();
        bus.in_data[2*DATA_W +: DATA_W] = 16'h2002;
        bus.link_credit = 1'b1;
        bus.link_credit_vc = 2'd2;
        @(negedge clk);
        n_checks++;
        if (bus.credit_cnt[2*CNT_W +: CNT_W] !== 3'd2) begin n_fail++; $display("FAIL sendret_pre_cnt: got %0d expected 2", bus.credit_cnt[2*CNT_W +: CNT_W]); end
        step();
        bus.in_valid[2] = 1'b0;
        bus.link_credit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.credit_cnt[2*CNT_W +: CNT_W] !== 3'd2) begin n_fail++; $display("FAIL sendret_cnt: got %0d expected 2", bus.credit_cnt[2*CNT_W +: CNT_W]); end
        n_checks++;
        if (bus.link_enable !== 1'b1 || bus.link_vc !== 2'd2 || bus.link_data !== 16'h2002) begin
            n_fail++;
            $display("FAIL sendret_link: got en %b vc %0d data %h expected en 1 vc 2 data 2002", bus.link_enable, bus.link_vc, bus.link_data);
        end
        step();
    endtask

    task automatic test_errors;
        apply_reset();
        bus.in_valid[0] = 1'b1;
        bus.in_data[0 +: DATA_W] = 16'h5555;
        bus.link_credit = 1'b1;
        bus.link_credit_vc = 2'd0;
        step();
        bus.in_valid[0] = 1'b0;
        bus.link_credit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.credit_cnt[0 +: CNT_W] !== 3'd4 || bus.credit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_send_return: got cnt %0d err %b expected cnt 4 err 0", bus.credit_cnt[0 +: CNT_W], bus.credit_err);
        end
        step();
        bus.link_credit = 1'b1;
        bus.link_credit_vc = 2'd0;
        step();
        bus.link_credit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.credit_cnt[0 +: CNT_W] !== 3'd4 || bus.credit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got cnt %0d err %b expected cnt 4 err 1", bus.credit_cnt[0 +: CNT_W], bus.credit_err);
        end
        step();
        bus.in_valid[3] = 1'b1;
        bus.in_data[3*DATA_W +: DATA_W] = 16'h7777;
        step();
        bus.in_valid[3] = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_checks++;
        if (bus.credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", bus.credit_err); end
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (bus.credit_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", bus.credit_err); end
        step();
    endtask

    task automatic test_bad_vc;
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (bus3.credit_err !== 1'b0 || bus3.credit_cnt !== 6'b10_10_10) begin
            n_fail++;
            $display("FAIL badvc_reset: got err %b cnt %b expected err 0 cnt 101010", bus3.credit_err, bus3.credit_cnt);
        end
        step();
        bus3.link_credit = 1'b1;
        bus3.link_credit_vc = 2'd3;
        step();
        bus3.link_credit = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus3.credit_err !== 1'b1 || bus3.credit_cnt !== 6'b10_10_10) begin
            n_fail++;
            $display("FAIL badvc: got err %b cnt %b expected err 1 cnt 101010", bus3.credit_err, bus3.credit_cnt);
        end
        step();
    endtask

    task automatic test_idle_gaps;
        apply_reset();
        bus.in_valid[3] = 1'b1;
        bus.in_data[3*DATA_W +: DATA_W] = 16'h3000;
        step();
        bus.in_valid[3] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.link_enable !== 1'b1 || bus.link_vc !== 2'd3 || bus.link_data !== 16'h3000) begin
            n_fail++;
            $display("FAIL idle_first: got en %b vc %0d data %h expected en 1 vc 3 data 3000", bus.link_enable, bus.link_vc, bus.link_data);
        end
        step();
        bus.in_valid[3] = 1'b1;
        bus.in_data[3*DATA_W +: DATA_W] = 16'h3002;
        @(negedge clk);
        n_checks++;
        if (bus.link_enable !== 1'b0 || bus.link_vc !== 2'd0 || bus.link_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_gap: got en %b vc %0d data %h expected en 0 vc 0 data 0000", bus.link_enable, bus.link_vc, bus.link_data);
        end
        step();
        bus.in_valid[3] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.link_enable !== 1'b1 || bus.link_data !== 16'h3002) begin
            n_fail++;
            $display("FAIL idle_second: got en %b data %h expected en 1 data 3002", bus.link_enable, bus.link_data);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.link_credit = 1'b0;
        bus.link_credit_vc = '0;
        bus3.in_valid = '0;
        bus3.in_data = '0;
        bus3.link_credit = 1'b0;
        bus3.link_credit_vc = '0;

        test_reset();
        test_exhaust();
        test_round_robin();
        test_send_return();
        test_errors();
        test_bad_vc();
        test_idle_gaps();

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending flits expected 0", sb_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
